// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed hex display driver for cascaded 4-bit counters.
//   A frame is DIGITS slots of SCAN_DIV cycles each. All digit values are snapshotted
//   once per frame, so a frame never mixes old and new values. The first BLANK_CYC
//   cycles of each slot turn every digit off to suppress ghosting. Leading zeros can
//   optionally be blanked.
// Ports:
//   CP       clock, rising edge
//   CR       synchronous active-high reset
//   data_in  digit values, [4k+3:4k] = digit k, digit 0 least significant
//   dp_in    per-digit decimal point request, 1 = on
//   lzb_en   1 = blank leading zeros
//   seg      {g,f,e,d,c,b,a}, active-low, registered
//   dp       decimal point, active-low, registered
//   an       digit enables, active-low, at most one low, registered
module seg7_scan_display #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic                  CP,
   input  logic                  CR,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  lzb_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
   localparam logic [6:0]       SEG_OFF   = 7'h7F;

   logic [DIV_W-1:0]    div;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] snap_data;
   logic [DIGITS-1:0]   snap_dp;

   logic                div_wrap_c;
   logic                frame_end_c;
   logic [DIGITS-1:0]   lz_blank_c;
   logic [3:0]          cur_nib_c;
   logic                cur_dp_req_c;
   logic                cur_blank_c;
   logic [6:0]          seg_dec_c;
   logic                all_zero_c;

   assign div_wrap_c  = (div == DIV_LAST);
   assign frame_end_c = div_wrap_c && (idx == IDX_LAST);

   // Digit k is a leading zero when it and every more significant digit are zero
   always_comb begin
      lz_blank_c = '0;
      all_zero_c = 1'b1;
      for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
         all_zero_c    = all_zero_c && (snap_data[4*k +: 4] == 4'h0);
         lz_blank_c[k] = lzb_en && all_zero_c;
      end
   end

   // Select the snapshot fields of the digit in the current slot
   always_comb begin
      cur_nib_c    = 4'h0;
      cur_dp_req_c = 1'b0;
      cur_blank_c  = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (IDX_W'(k) == idx) begin
            cur_nib_c    = snap_data[4*k +: 4];
            cur_dp_req_c = snap_dp[k];
            cur_blank_c  = lz_blank_c[k];
         end
      end
   end

   // Hex to active-low 7-segment pattern
   always_comb begin
      seg_dec_c = SEG_OFF;
      unique case (cur_nib_c)
         4'h0: seg_dec_c = 7'h40;
         4'h1: seg_dec_c = 7'h79;
         4'h2: seg_dec_c = 7'h24;
         4'h3: seg_dec_c = 7'h30;
         4'h4: seg_dec_c = 7'h19;
         4'h5: seg_dec_c = 7'h12;
         4'h6: seg_dec_c = 7'h02;
         4'h7: seg_dec_c = 7'h78;
         4'h8: seg_dec_c = 7'h00;
         4'h9: seg_dec_c = 7'h10;
         4'hA: seg_dec_c = 7'h08;
         4'hB: seg_dec_c = 7'h03;
         4'hC: seg_dec_c = 7'h46;
         4'hD: seg_dec_c = 7'h21;
         4'hE: seg_dec_c = 7'h06;
         4'hF: seg_dec_c = 7'h0E;
         default: seg_dec_c = SEG_OFF;
      endcase
   end

   // Scan counters, frame snapshot and registered outputs (from this cycle's state)
   always_ff @(posedge CP) begin
      if (CR) begin
         div       <= '0;
         idx       <= '0;
         snap_data <= '0;
         snap_dp   <= '0;
         an        <= '1;
         seg       <= SEG_OFF;
         dp        <= 1'b1;
      end else begin
         if (div_wrap_c) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end else begin
            div <= div + DIV_W'(1);
         end

         if (frame_end_c) begin
            snap_data <= data_in;
            snap_dp   <= dp_in;
         end

         if (div < BLANK_END) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
         end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= cur_blank_c ? SEG_OFF : seg_dec_c;
            dp  <= cur_blank_c | ~cur_dp_req_c;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: scoreboard bench for seg7_scan_display (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seg7_scan_display;

   localparam int unsigned DIGITS    = 4;
   localparam int unsigned SCAN_DIV  = 8;
   localparam int unsigned BLANK_CYC = 2;
   localparam int unsigned FRAME     = DIGITS * SCAN_DIV;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic        CP = 1'b0;
   logic        CR;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        lzb_en;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;

   exp_t sb[$];

   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Per-slot observations from a mid-slot cycle of the most recent frame
   logic [6:0] obs_seg [4];
   logic       obs_dp  [4];
   logic [3:0] obs_an  [4];

   seg7_scan_display #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .BLANK_CYC(BLANK_CYC)
   ) dut (
      .CP     (CP),
      .CR     (CR),
      .data_in(data_in),
      .dp_in  (dp_in),
      .lzb_en (lzb_en),
      .seg    (seg),
      .dp     (dp),
      .an     (an)
   );

   always #5 CP = ~CP;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Cycle model: frame position counter, snapshot, expected output pushed per edge
   initial begin : monitor
      int   m_t;
      int   slot;
      int   pos;
      int   obs_slot;
      logic [15:0] m_snap;
      logic [3:0]  m_snapdp;
      logic        blank;
      exp_t e;
      exp_t g;
      m_t = 0; m_snap = '0; m_snapdp = '0;
      forever begin
         @(posedge CP);
         obs_slot = -1;
         if (CR) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
            m_t = 0; m_snap = '0; m_snapdp = '0;
         end else begin
            slot = m_t / int'(SCAN_DIV);
            pos  = m_t % int'(SCAN_DIV);
            if (pos < int'(BLANK_CYC)) begin
               e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
            end else begin
               blank = lzb_en && (slot > 0) && ((m_snap >> (4 * slot)) == 16'h0);
               e.an  = 4'hF & ~(4'b0001 << slot);
               e.seg = blank ? 7'h7F : tbl[m_snap[4*slot +: 4]];
               e.dp  = blank ? 1'b1 : ~m_snapdp[slot];
            end
            if (pos == 5) obs_slot = slot;
            if (m_t == int'(FRAME) - 1) begin
               m_snap   = data_in;
               m_snapdp = dp_in;
            end
            m_t = (m_t + 1) % int'(FRAME);
         end
         sb.push_back(e);
         #1;
         g = '{an: an, seg: seg, dp: dp};
         e = sb.pop_front();
         check("an",  32'(g.an),  32'(e.an));
         check("seg", 32'(g.seg), 32'(e.seg));
         check("dp",  32'(g.dp),  32'(e.dp));
         check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
         if (obs_slot >= 0) begin
            obs_seg[obs_slot] = seg;
            obs_dp[obs_slot]  = dp;
            obs_an[obs_slot]  = an;
         end
      end
   end

   task automatic wait_neg(input int n);
      repeat (n) @(negedge CP);
   endtask

   // Compare the last frame's per-digit observations against literal patterns
   task automatic frame_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] s [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s_seg%0d", tag, k), 32'(obs_seg[k]), 32'(s[k]));
         check($sformatf("%s_an%0d", tag, k), 32'(obs_an[k]), 32'(4'hF ^ (4'h1 << k)));
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : main
      CR = 1'b1; data_in = '0; dp_in = '0; lzb_en = 1'b0;
      // 1: reset for two edges, then a frame of zeros
      wait_neg(2);
      check("rst_an",  32'(an),  32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp",  32'(dp),  32'h1);
      CR = 1'b0;
      data_in = 16'h1234;
      wait_neg(FRAME);
      frame_check("zeros", 7'h40, 7'h40, 7'h40, 7'h40);
      // 2: 1234 shown in the second frame
      wait_neg(FRAME);
      frame_check("h1234", 7'h19, 7'h30, 7'h24, 7'h79);
      // 3: leading-zero blanking
      lzb_en = 1'b1; data_in = 16'h0070;
      wait_neg(FRAME);
      frame_check("h1234_lzb", 7'h19, 7'h30, 7'h24, 7'h79);
      data_in = 16'h0000;
      wait_neg(FRAME);
      frame_check("h0070_lzb", 7'h40, 7'h78, 7'h7F, 7'h7F);
      lzb_en = 1'b0;
      lzb_en = 1'b1;
      data_in = 16'h1111;
      wait_neg(FRAME);
      frame_check("h0000_lzb", 7'h40, 7'h7F, 7'h7F, 7'h7F);
      // 4: input changes mid-frame do not reach the display until the next frame
      lzb_en = 1'b0;
      wait_neg(SCAN_DIV + 3);
      data_in = 16'h2222;
      wait_neg(FRAME - SCAN_DIV - 3);
      frame_check("h1111_snap", 7'h79, 7'h79, 7'h79, 7'h79);
      dp_in = 4'b0101; data_in = 16'h8888;
      wait_neg(FRAME);
      frame_check("h2222", 7'h24, 7'h24, 7'h24, 7'h24);
      // 6: decimal points
      wait_neg(FRAME);
      frame_check("h8888", 7'h00, 7'h00, 7'h00, 7'h00);
      check("dp0", 32'(obs_dp[0]), 32'h0);
      check("dp1", 32'(obs_dp[1]), 32'h1);
      check("dp2", 32'(obs_dp[2]), 32'h0);
      check("dp3", 32'(obs_dp[3]), 32'h1);
      // 5: reset at idx=2, div=4 clears the snapshot and restarts at digit 0
      wait_neg(2 * SCAN_DIV + 4);
      CR = 1'b1;
      wait_neg(1);
      check("midrst_an",  32'(an),  32'hF);
      check("midrst_seg", 32'(seg), 32'h7F);
      CR = 1'b0;
      wait_neg(FRAME);
      frame_check("after_rst", 7'h40, 7'h40, 7'h40, 7'h40);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
